// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch and load/store ports with a watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default build uses fixed LS priority.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        ls_rd_en_i,
    input  logic        ls_wr_en_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_data_i,
    output logic [31:0] ls_data_o,
    output logic        ls_ack_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_LS, RECOVER} state_t;
    state_t state, state_nxt;
    logic last_gnt;
    logic [CNT_W-1:0] wd_cnt;
    logic ls_req, pick_ls, gnt, abort;
    assign ls_req = ls_rd_en_i | ls_wr_en_i;
`ifdef ARB_ROUND_ROBIN_EN
    // last_gnt=1 means LS was granted last, so IF wins the next tie
    assign pick_ls = ls_req & (~if_req_i | ~last_gnt);
`else
    assign pick_ls = ls_req | (last_gnt & 1'b0);
`endif
    assign gnt   = (state == GNT_IF) || (state == GNT_LS);
    assign abort = gnt && (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT - 1)) && !mem_ack_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt != IDLE) begin
                last_gnt <= (state_nxt == GNT_LS);
                wd_cnt   <= '0;
            end else if (gnt && !mem_ack_i) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
    always_comb begin
        state_nxt   = IDLE;
        if_data_o   = '0;
        if_ack_o    = 1'b0;
        ls_data_o   = '0;
        ls_ack_o    = 1'b0;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        busy_o      = gnt;
        err_o       = abort;
        case (state)
            IDLE:    state_nxt = pick_ls ? GNT_LS : (if_req_i ? GNT_IF : IDLE);
            GNT_IF,
            GNT_LS:  state_nxt = (mem_ack_i || abort) ? RECOVER : state;
            default: state_nxt = IDLE;
        endcase
        if (state == GNT_IF) begin
            mem_rd_en_o = !abort;
            mem_addr_o  = if_addr_i;
            if_ack_o    = mem_ack_i | abort;
            if_data_o   = abort ? '0 : mem_data_i;
        end
        if (state == GNT_LS) begin
            mem_rd_en_o = ls_rd_en_i & !abort;
            mem_wr_en_o = ls_wr_en_i & !abort;
            mem_addr_o  = ls_addr_i;
            mem_data_o  = ls_data_i;
            ls_ack_o    = mem_ack_i | abort;
            ls_data_o   = abort ? '0 : mem_data_i;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a zero-wait memory model.
module tb_mem_port_arbiter;
    logic        clk = 0, rst = 1;
    logic        if_req_i = 0, ls_rd_en_i = 0, ls_wr_en_i = 0;
    logic [31:0] if_addr_i = 0, ls_addr_i = 0, ls_data_i = 0;
    logic [31:0] if_data_o, ls_data_o, mem_addr_o, mem_data_o, mem_data_i;
    logic        if_ack_o, ls_ack_o, mem_rd_en_o, mem_wr_en_o, mem_ack_i, busy_o, err_o;
    logic        ack_en = 1, pl_en = 0;
    logic [5:0]  pl_idx = 0;
    logic [31:0] pl_val = 0;
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .ls_rd_en_i(ls_rd_en_i), .ls_wr_en_i(ls_wr_en_i), .ls_addr_i(ls_addr_i),
        .ls_data_i(ls_data_i), .ls_data_o(ls_data_o), .ls_ack_o(ls_ack_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    // zero-wait memory: combinational read and ack, write at the clock edge
    assign mem_ack_i  = ack_en & (mem_rd_en_o | mem_wr_en_o);
    assign mem_data_i = mem[mem_addr_o[7:2]];
    always @(posedge clk)
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (ack_en && mem_wr_en_o) mem[mem_addr_o[7:2]] <= mem_data_o;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] i, input logic [31:0] v);
        pl_en = 1; pl_idx = i; pl_val = v; ref_mem[i] = v;
        tick;
        pl_en = 0;
    endtask

    task automatic pulse_reset;
        rst = 1;
        tick;
        rst = 0;
    endtask

    task automatic test_reset;
        logic [163:0] outs;
        rst = 1;
        tick; tick;
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            outs = {if_data_o, if_ack_o, ls_data_o, ls_ack_o, mem_rd_en_o, mem_wr_en_o,
                    mem_addr_o, mem_data_o, busy_o, err_o};
            total++;
            if (outs !== '0) begin bad++; $display("FAIL reset_outs cycle %0d got %h want 0", i, outs); end
        end
    endtask

    task automatic test_fetch;
        preload(6'd4, 32'hDEADBEEF);
        if_req_i = 1; if_addr_i = 32'h10;
        #1;
        total++;
        if (busy_o !== 0) begin bad++; $display("FAIL fetch_idle busy got %b want 0", busy_o); end
        tick;
        total++;
        if ({if_ack_o, mem_rd_en_o, ls_ack_o} !== 3'b110) begin
            bad++; $display("FAIL fetch_ack ack/rd/ls got %b%b%b want 110", if_ack_o, mem_rd_en_o, ls_ack_o);
        end
        total++;
        if (if_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_data got %h want deadbeef", if_data_o); end
        tick;
        if_req_i = 0;
        total++;
        if ({busy_o, mem_rd_en_o, if_ack_o} !== 3'b000) begin
            bad++; $display("FAIL fetch_recover busy/rd/ack got %b%b%b want 000", busy_o, mem_rd_en_o, if_ack_o);
        end
        tick;
        total++;
        if (busy_o !== 0) begin bad++; $display("FAIL fetch_idle2 busy got %b want 0", busy_o); end
    endtask

    task automatic test_store_load;
        ls_wr_en_i = 1; ls_addr_i = 32'h20; ls_data_i = 32'h12345678;
        tick;
        total++;
        if ({ls_ack_o, mem_wr_en_o, mem_rd_en_o} !== 3'b110 || mem_data_o !== 32'h12345678) begin
            bad++; $display("FAIL store ack/wr/rd got %b%b%b data %h want 110 12345678",
                            ls_ack_o, mem_wr_en_o, mem_rd_en_o, mem_data_o);
        end
        ref_mem[8] = 32'h12345678;
        tick;
        ls_wr_en_i = 0; ls_data_i = 0;
        tick;
        ls_rd_en_i = 1;
        tick;
        total++;
        if (ls_ack_o !== 1 || ls_data_o !== 32'h12345678 || mem_wr_en_o !== 0) begin
            bad++; $display("FAIL load ack %b data %h wr %b want 1 12345678 0", ls_ack_o, ls_data_o, mem_wr_en_o);
        end
        tick;
        ls_rd_en_i = 0;
        tick;
    endtask

    task automatic test_contention;
        string seq = "", exp_seq;
        bit dual = 0;
        pulse_reset;
        if_req_i = 1; if_addr_i = 32'h10; ls_rd_en_i = 1; ls_addr_i = 32'h20;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (if_ack_o && ls_ack_o) dual = 1;
            if (ls_ack_o) seq = {seq, "L"};
            else if (if_ack_o) seq = {seq, "I"};
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = "LILI";
`else
        exp_seq = "LLLL";
`endif
        total++;
        if (seq != exp_seq) begin bad++; $display("FAIL contention_order got %s want %s", seq, exp_seq); end
        total++;
        if (dual !== 0) begin bad++; $display("FAIL contention_dual_ack got %b want 0", dual); end
        if_req_i = 0; ls_rd_en_i = 0;
        tick;
    endtask

    task automatic test_timeout;
        ack_en = 0;
        ls_wr_en_i = 1; ls_addr_i = 32'h30; ls_data_i = 32'hCAFEF00D;
        for (int c = 1; c <= 4; c++) begin
            tick;
            total++;
            if (c < 4 && {ls_ack_o, err_o, mem_wr_en_o} !== 3'b001) begin
                bad++; $display("FAIL timeout_wait cycle %0d ack/err/wr got %b%b%b want 001", c, ls_ack_o, err_o, mem_wr_en_o);
            end
            if (c == 4 && ({ls_ack_o, err_o, mem_wr_en_o} !== 3'b110 || ls_data_o !== 0)) begin
                bad++; $display("FAIL timeout_abort ack/err/wr got %b%b%b data %h want 110 0",
                                ls_ack_o, err_o, mem_wr_en_o, ls_data_o);
            end
        end
        tick;
        ls_wr_en_i = 0;
        total++;
        if ({err_o, busy_o} !== 2'b00) begin bad++; $display("FAIL timeout_recover err/busy got %b%b want 00", err_o, busy_o); end
        total++;
        if (mem[12] !== ref_mem[12]) begin bad++; $display("FAIL timeout_nowrite mem got %h want %h", mem[12], ref_mem[12]); end
        ack_en = 1;
        tick;
    endtask

    task automatic test_reset_mid;
        ack_en = 0;
        ls_rd_en_i = 1; ls_addr_i = 32'h30;
        tick;
        total++;
        if ({busy_o, ls_ack_o} !== 2'b10) begin bad++; $display("FAIL midrst_grant busy/ack got %b%b want 10", busy_o, ls_ack_o); end
        rst = 1;
        tick;
        total++;
        if ({busy_o, ls_ack_o, mem_rd_en_o, mem_wr_en_o} !== 4'b0000) begin
            bad++; $display("FAIL midrst_after busy/ack/rd/wr got %b%b%b%b want 0000", busy_o, ls_ack_o, mem_rd_en_o, mem_wr_en_o);
        end
        rst = 0; ls_rd_en_i = 0; ack_en = 1;
        tick;
    endtask

    task automatic test_random;
        bit pi, pl, r, w, exp_ls, last_ls, got;
        int kind, lat;
        logic [31:0] fa, la, ld;
        pulse_reset;
        last_ls = 0;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            pi = (kind != 1); pl = (kind != 0);
            r = $urandom_range(0, 1); w = $urandom_range(0, 1);
            if (!r && !w) r = 1;
            fa = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            la = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            ld = $urandom;
            if_req_i = pi; if_addr_i = fa;
            ls_rd_en_i = pl & r; ls_wr_en_i = pl & w; ls_addr_i = la; ls_data_i = ld;
            while (pi || pl) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_ls = pl && (!pi || !last_ls);
`else
                exp_ls = pl;
`endif
                got = 0; lat = 0;
                while (!got && lat < 4) begin
                    tick;
                    lat++;
                    got = if_ack_o | ls_ack_o;
                end
                total++;
                if (!got || lat != 1) begin
                    bad++; $display("FAIL rand_latency txn %0d got %0d cycles (ack %b) want 1", t, lat, got);
                    pi = 0; pl = 0;
                end else begin
                    total++;
                    if ({ls_ack_o, if_ack_o} !== {exp_ls, !exp_ls}) begin
                        bad++; $display("FAIL rand_winner txn %0d ls/if ack got %b%b want %b%b", t, ls_ack_o, if_ack_o, exp_ls, !exp_ls);
                    end
                    if (exp_ls) begin
                        if (r) begin
                            total++;
                            if (ls_data_o !== ref_mem[la[7:2]]) begin
                                bad++; $display("FAIL rand_ls_data txn %0d got %h want %h", t, ls_data_o, ref_mem[la[7:2]]);
                            end
                        end
                        if (w) ref_mem[la[7:2]] = ld;
                        pl = 0; last_ls = 1;
                    end else begin
                        total++;
                        if (if_data_o !== ref_mem[fa[7:2]]) begin
                            bad++; $display("FAIL rand_if_data txn %0d got %h want %h", t, if_data_o, ref_mem[fa[7:2]]);
                        end
                        pi = 0; last_ls = 0;
                    end
                end
                tick;
                if (!pl) begin ls_rd_en_i = 0; ls_wr_en_i = 0; end
                if (!pi) if_req_i = 0;
                tick;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) preload(6'(i), $urandom | 32'h1);
        test_reset;
        test_fetch;
        test_store_load;
        test_contention;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
